// File: rtl/sd_fifo_sync_pkg.sv
// sd_fifo_sync_pkg: shared constants and sizing helper for the sd FIFO slice
package sd_fifo_sync_pkg;
    localparam int SD_WIDTH = 8;
    localparam int SD_DEPTH = 4;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction
endpackage

// File: rtl/sd_fifo_sync_if.sv
// sd_fifo_sync_if: srdy/drdy write (c_*) and read (p_*) ports of the FIFO
interface sd_fifo_sync_if import sd_fifo_sync_pkg::*; #(parameter int width = SD_WIDTH);
    logic             c_srdy, c_drdy, p_srdy, p_drdy;
    logic [width-1:0] c_data, p_data;
    modport master (output c_srdy, c_data, p_drdy, input c_drdy, p_srdy, p_data);
    modport slave  (input c_srdy, c_data, p_drdy, output c_drdy, p_srdy, p_data);
endinterface

// File: rtl/sd_fifo_sync_half_reg.sv
// sd_half_reg: one-entry half buffer that registers p_* outputs
module sd_half_reg #(parameter int width = 8) (
    input  logic             clk,
    input  logic             reset,
    input  logic             c_srdy,
    output logic             c_drdy,
    input  logic [width-1:0] c_data,
    output logic             p_srdy,
    input  logic             p_drdy,
    output logic [width-1:0] p_data
);
    logic valid;
    assign c_drdy = !valid;
    assign p_srdy = valid;
    // loads only while empty, so at most one word per two cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            valid  <= 1'b0;
            p_data <= '0;
        end else if (c_srdy && !valid) begin
            valid  <= 1'b1;
            p_data <= c_data;
        end else if (valid && p_drdy) begin
            valid  <= 1'b0;
        end
    end
endmodule

// File: rtl/sd_fifo_sync.sv
// sd_fifo_sync: single-clock srdy/drdy FIFO with optional registered output
module sd_fifo_sync import sd_fifo_sync_pkg::*; #(
    parameter int width = SD_WIDTH,
    parameter int depth = SD_DEPTH,
    parameter int oreg  = 0
) (
    input logic            clk,
    input logic            reset,
    sd_fifo_sync_if.slave  io
);
    localparam int aw = clog2(depth);
    logic [aw:0]      wr_ptr, rd_ptr;
    logic [width-1:0] mem [depth];
    logic             full, empty, core_srdy, core_drdy;
    logic [width-1:0] core_data;
    assign empty     = wr_ptr == rd_ptr;
    assign full      = (wr_ptr[aw-1:0] == rd_ptr[aw-1:0]) && (wr_ptr[aw] != rd_ptr[aw]);
    assign io.c_drdy = !full;
    assign core_srdy = !empty;
    assign core_data = mem[rd_ptr[aw-1:0]];
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (io.c_srdy && !full) wr_ptr <= wr_ptr + 1'b1;
            if (core_srdy && core_drdy) rd_ptr <= rd_ptr + 1'b1;
        end
    end
    always_ff @(posedge clk)
        if (io.c_srdy && !full) mem[wr_ptr[aw-1:0]] <= io.c_data;
    generate
        if (oreg != 0) begin : g_oreg
            sd_half_reg #(.width(width)) u_half (
                .clk(clk), .reset(reset),
                .c_srdy(core_srdy), .c_drdy(core_drdy), .c_data(core_data),
                .p_srdy(io.p_srdy), .p_drdy(io.p_drdy), .p_data(io.p_data)
            );
        end else begin : g_direct
            assign io.p_srdy = core_srdy;
            assign io.p_data = core_data;
            assign core_drdy = io.p_drdy;
        end
    endgenerate
endmodule

// File: tb/tb_sd_fifo_sync.sv
// tb_sd_fifo_sync: directed checks of sd_fifo_sync with and without output register
module tb_sd_fifo_sync;
    logic clk = 0, reset = 1;
    int vec = 0, errs = 0;
    always #5 clk = ~clk;
    sd_fifo_sync_if #(.width(8)) ia ();
    sd_fifo_sync_if #(.width(8)) ib ();
    sd_fifo_sync #(.width(8), .depth(4), .oreg(0)) dut_a (.clk(clk), .reset(reset), .io(ia));
    sd_fifo_sync #(.width(8), .depth(4), .oreg(1)) dut_b (.clk(clk), .reset(reset), .io(ib));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        ia.c_srdy = 0; ia.c_data = 0; ia.p_drdy = 0;
        ib.c_srdy = 0; ib.c_data = 0; ib.p_drdy = 0;
        reset = 1;
        tick();
        vec++; if (ia.c_drdy !== 1'b1) begin errs++; $display("FAIL rst_cdrdy_during: got %b want 1", ia.c_drdy); end
        vec++; if (ia.p_srdy !== 1'b0) begin errs++; $display("FAIL rst_psrdy_during: got %b want 0", ia.p_srdy); end
        tick();
        reset = 0;
        tick();
        vec++; if (ia.c_drdy !== 1'b1) begin errs++; $display("FAIL rst_a_cdrdy: got %b want 1", ia.c_drdy); end
        vec++; if (ia.p_srdy !== 1'b0) begin errs++; $display("FAIL rst_a_psrdy: got %b want 0", ia.p_srdy); end
        vec++; if (ib.c_drdy !== 1'b1) begin errs++; $display("FAIL rst_b_cdrdy: got %b want 1", ib.c_drdy); end
        vec++; if (ib.p_srdy !== 1'b0) begin errs++; $display("FAIL rst_b_psrdy: got %b want 0", ib.p_srdy); end
    endtask

    task automatic test_fill_drain();
        ia.p_drdy = 0;
        for (int i = 1; i <= 5; i++) begin
            ia.c_srdy = 1; ia.c_data = 8'(i);
            vec++; if (ia.c_drdy !== (i <= 4)) begin errs++; $display("FAIL fill_cdrdy[%0d]: got %b want %b", i, ia.c_drdy, i <= 4); end
            tick();
        end
        ia.c_srdy = 0;
        vec++; if (ia.c_drdy !== 1'b0) begin errs++; $display("FAIL fill_full: got %b want 0", ia.c_drdy); end
        ia.p_drdy = 1;
        for (int i = 1; i <= 4; i++) begin
            vec++; if (ia.p_srdy !== 1'b1 || ia.p_data !== 8'(i)) begin errs++; $display("FAIL drain[%0d]: got srdy=%b data=%0d want srdy=1 data=%0d", i, ia.p_srdy, ia.p_data, i); end
            tick();
        end
        ia.p_drdy = 0;
        vec++; if (ia.p_srdy !== 1'b0) begin errs++; $display("FAIL drain_empty: got %b want 0", ia.p_srdy); end
    endtask

    task automatic test_stream();
        ia.p_drdy = 1;
        for (int k = 0; k <= 16; k++) begin
            ia.c_srdy = k < 16; ia.c_data = 8'(k);
            vec++; if (ia.p_srdy !== (k >= 1) || (k >= 1 && ia.p_data !== 8'(k - 1))) begin errs++; $display("FAIL stream[%0d]: got srdy=%b data=%0d want srdy=%b data=%0d", k, ia.p_srdy, ia.p_data, k >= 1, k - 1); end
            vec++; if (ia.c_drdy !== 1'b1) begin errs++; $display("FAIL stream_cdrdy[%0d]: got %b want 1", k, ia.c_drdy); end
            tick();
        end
        ia.c_srdy = 0; ia.p_drdy = 0;
        vec++; if (ia.p_srdy !== 1'b0) begin errs++; $display("FAIL stream_end: got %b want 0", ia.p_srdy); end
    endtask

    task automatic test_full_read();
        ia.p_drdy = 0;
        for (int i = 0; i < 4; i++) begin
            ia.c_srdy = 1; ia.c_data = 8'(10 + i);
            tick();
        end
        ia.c_data = 14; ia.p_drdy = 1;
        vec++; if (ia.c_drdy !== 1'b0 || ia.p_data !== 8'd10) begin errs++; $display("FAIL full_rd: got cdrdy=%b data=%0d want cdrdy=0 data=10", ia.c_drdy, ia.p_data); end
        tick();
        ia.p_drdy = 0;
        vec++; if (ia.c_drdy !== 1'b1) begin errs++; $display("FAIL full_rd_after: got %b want 1", ia.c_drdy); end
        tick();
        ia.c_srdy = 0;
        vec++; if (ia.c_drdy !== 1'b0) begin errs++; $display("FAIL full_rd_refill: got %b want 0", ia.c_drdy); end
        ia.p_drdy = 1;
        for (int i = 11; i <= 14; i++) begin
            vec++; if (ia.p_srdy !== 1'b1 || ia.p_data !== 8'(i)) begin errs++; $display("FAIL full_drain[%0d]: got srdy=%b data=%0d want srdy=1 data=%0d", i, ia.p_srdy, ia.p_data, i); end
            tick();
        end
        ia.p_drdy = 0;
        vec++; if (ia.p_srdy !== 1'b0) begin errs++; $display("FAIL full_empty: got %b want 0", ia.p_srdy); end
    endtask

    task automatic test_wrap();
        logic [7:0] e;
        e = 40;
        ia.c_srdy = 1; ia.c_data = 40; ia.p_drdy = 0;
        tick();
        for (int k = 0; k < 10; k++) begin
            ia.c_data = 8'(41 + k); ia.p_drdy = !(k == 3 || k == 7);
            vec++; if (ia.p_srdy !== 1'b1 || ia.p_data !== e) begin errs++; $display("FAIL wrap[%0d]: got srdy=%b data=%0d want srdy=1 data=%0d", k, ia.p_srdy, ia.p_data, e); end
            if (ia.p_drdy) e++;
            tick();
        end
        ia.c_srdy = 0; ia.p_drdy = 1;
        for (int k = 0; k < 3; k++) begin
            vec++; if (ia.p_srdy !== 1'b1 || ia.p_data !== e) begin errs++; $display("FAIL wrap_drain[%0d]: got srdy=%b data=%0d want srdy=1 data=%0d", k, ia.p_srdy, ia.p_data, e); end
            e++;
            tick();
        end
        ia.p_drdy = 0;
        vec++; if (ia.p_srdy !== 1'b0) begin errs++; $display("FAIL wrap_empty: got %b want 0", ia.p_srdy); end
    endtask

    task automatic test_oreg();
        int n, got;
        logic [7:0] e;
        n = 0;
        ib.p_drdy = 1;
        for (int c = 0; c < 18; c++) begin
            ib.c_srdy = n < 8; ib.c_data = 8'(8'hA0 + n);
            e = 8'(8'hA0 + (c - 2) / 2);
            vec++; if (ib.p_srdy !== (c >= 2 && c % 2 == 0) || (ib.p_srdy && ib.p_data !== e)) begin errs++; $display("FAIL oreg_stream[%0d]: got srdy=%b data=%0h want srdy=%b data=%0h", c, ib.p_srdy, ib.p_data, c >= 2 && c % 2 == 0, e); end
            if (ib.c_srdy && ib.c_drdy) n++;
            tick();
        end
        ib.c_srdy = 0; ib.p_drdy = 0;
        for (int c = 0; c < 7; c++) begin
            ib.c_srdy = 1; ib.c_data = 8'(8'hB0 + c);
            vec++; if (ib.c_drdy !== (c < 5)) begin errs++; $display("FAIL oreg_cap[%0d]: got cdrdy=%b want %b", c, ib.c_drdy, c < 5); end
            tick();
        end
        ib.c_srdy = 0; ib.p_drdy = 1;
        got = 0;
        for (int c = 0; c < 14; c++) begin
            if (ib.p_srdy) begin
                vec++; if (ib.p_data !== 8'(8'hB0 + got)) begin errs++; $display("FAIL oreg_drain[%0d]: got %0h want %0h", got, ib.p_data, 8'hB0 + got); end
                got++;
            end
            tick();
        end
        ib.p_drdy = 0;
        vec++; if (got != 5) begin errs++; $display("FAIL oreg_count: got %0d words want 5", got); end
    endtask

    task automatic test_reset_mid();
        ia.p_drdy = 0;
        for (int i = 0; i < 3; i++) begin
            ia.c_srdy = 1; ia.c_data = 8'(70 + i);
            tick();
        end
        ia.c_srdy = 0; reset = 1;
        tick();
        reset = 0;
        vec++; if (ia.p_srdy !== 1'b0 || ia.c_drdy !== 1'b1) begin errs++; $display("FAIL mid_rst: got psrdy=%b cdrdy=%b want psrdy=0 cdrdy=1", ia.p_srdy, ia.c_drdy); end
        ia.c_srdy = 1; ia.c_data = 80;
        tick();
        ia.c_srdy = 0; ia.p_drdy = 1;
        vec++; if (ia.p_srdy !== 1'b1 || ia.p_data !== 8'd80) begin errs++; $display("FAIL mid_rst_new: got srdy=%b data=%0d want srdy=1 data=80", ia.p_srdy, ia.p_data); end
        tick();
        ia.p_drdy = 0;
        vec++; if (ia.p_srdy !== 1'b0) begin errs++; $display("FAIL mid_rst_only: got %b want 0", ia.p_srdy); end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_stream();
        test_full_read();
        test_wrap();
        test_oreg();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
